// File: rtl/vrf_pkg.sv
// Shared types and helpers for the streaming vector register file.
// Optional chaining between the writer and the readers is enabled with VRF_CHAIN_EN.
package vrf_pkg;

    typedef enum logic {eIdle, eStream} rd_state_e;
    typedef enum logic {eWrIdle, eWrite} wr_state_e;

    localparam int unsigned max_lanes_lp = 64;

    function automatic int unsigned clamp_vl_f(int unsigned vl, int unsigned vlen);
        return (vl > vlen) ? vlen : vl;
    endfunction

    function automatic int unsigned beats_f(int unsigned vl, int unsigned lanes);
        return (vl + lanes - 1) / lanes;
    endfunction

    // Bit l is set when element b*lanes+l lies inside the vector length.
    function automatic logic [max_lanes_lp-1:0] mask_f(int unsigned b, int unsigned vl,
                                                       int unsigned lanes);
        logic [max_lanes_lp-1:0] m;
        m = '0;
        for (int unsigned l = 0; l < max_lanes_lp; l++) begin
            if (l < lanes) m[l] = ((b * lanes + l) < vl);
        end
        return m;
    endfunction

endpackage

// File: rtl/vrf_rd_seq.sv
// One read-port sequencer: accepts a whole-vector request, then streams beats
// of lanes_p elements straight out of the shared storage array.
module vrf_rd_seq
    import vrf_pkg::*;
#(
    parameter int els_p   = 32,
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 32,
    parameter int lanes_p = 4
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          req_v_i,
    input  logic [$clog2(els_p)-1:0]                      req_reg_i,
    input  logic [$clog2(vlen_p+1)-1:0]                   req_vl_i,
    input  logic                                          req_ok_i,
    output logic                                          req_ready_o,
    input  logic [els_p-1:0][vlen_p-1:0][vdw_p-1:0]       mem_i,
    input  logic [((vlen_p/lanes_p > 1) ? $clog2(vlen_p/lanes_p) : 1):0] avail_i,
    output logic                                          v_o,
    output logic [lanes_p-1:0][vdw_p-1:0]                 data_o,
    output logic [lanes_p-1:0]                            mask_o,
    output logic                                          last_o,
    input  logic                                          yumi_i,
    output logic                                          stream_o,
    output logic [$clog2(els_p)-1:0]                      reg_o
);

    localparam int ra_w     = $clog2(els_p);
    localparam int vl_w     = $clog2(vlen_p + 1);
    localparam int beats_lp = vlen_p / lanes_p;
    localparam int bw_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;

    rd_state_e                 state_r, state_n;
    logic [ra_w-1:0]           reg_r;
    logic [vl_w-1:0]           vl_r;
    logic [bw_lp-1:0]          beat_r;
    logic [vl_w-1:0]           req_vl_c;
    logic [max_lanes_lp-1:0]   mask_full;
    logic                      last_c;
    logic                      accept;
    logic                      take;

    assign req_vl_c    = vl_w'(clamp_vl_f(32'(req_vl_i), vlen_p));
    assign req_ready_o = (state_r == eIdle) && req_ok_i;
    assign accept      = req_v_i && req_ready_o;
    assign stream_o    = (state_r == eStream);
    assign reg_o       = reg_r;
    // avail_i counts the beats already safe to read; it is the full vector unless chained.
    assign v_o         = stream_o && ({1'b0, beat_r} < avail_i);
    assign take        = yumi_i && v_o;
    assign last_c      = ((32'(beat_r) + 1) == beats_f(32'(vl_r), lanes_p));
    assign last_o      = stream_o && last_c;
    assign mask_o      = mask_full[lanes_p-1:0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state_r;
        case (state_r)
            eIdle:   if (accept && req_vl_c != '0) state_n = eStream;
            eStream: if (take && last_c) state_n = eIdle;
            default: state_n = eIdle;
        endcase
    end

    always_comb begin
        mask_full = mask_f(32'(beat_r), 32'(vl_r), lanes_p);
        for (int l = 0; l < lanes_p; l++) begin
            data_o[l] = mem_i[reg_r][32'(beat_r) * lanes_p + l];
        end
    end

    // NOTE: state is updated with non-blocking assignments only; blocking ones would race other flops.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIdle;
            reg_r   <= '0;
            vl_r    <= '0;
            beat_r  <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                reg_r  <= req_reg_i;
                vl_r   <= req_vl_c;
                beat_r <= '0;
            end else if (take) begin
                beat_r <= beat_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vrf_stream.sv
// Vector register file top: storage, write sequencer, busy scoreboard and read ports.
// Define VRF_CHAIN_EN to let a read stream behind the active write of the same register.
module vrf_stream
    import vrf_pkg::*;
#(
    parameter int els_p      = 32,
    parameter int vlen_p     = 8,
    parameter int vdw_p      = 32,
    parameter int lanes_p    = 4,
    parameter int rd_ports_p = 2
) (
    input  logic                                               clk_i,
    input  logic                                               reset_i,
    input  logic [rd_ports_p-1:0]                              rd_req_v_i,
    input  logic [rd_ports_p-1:0][$clog2(els_p)-1:0]           rd_req_reg_i,
    input  logic [rd_ports_p-1:0][$clog2(vlen_p+1)-1:0]        rd_req_vl_i,
    output logic [rd_ports_p-1:0]                              rd_req_ready_o,
    output logic [rd_ports_p-1:0]                              rd_v_o,
    output logic [rd_ports_p-1:0][lanes_p-1:0][vdw_p-1:0]      rd_data_o,
    output logic [rd_ports_p-1:0][lanes_p-1:0]                 rd_mask_o,
    output logic [rd_ports_p-1:0]                              rd_last_o,
    input  logic [rd_ports_p-1:0]                              rd_yumi_i,
    input  logic                                               wr_req_v_i,
    input  logic [$clog2(els_p)-1:0]                           wr_req_reg_i,
    input  logic [$clog2(vlen_p+1)-1:0]                        wr_req_vl_i,
    output logic                                               wr_req_ready_o,
    input  logic                                               wr_v_i,
    input  logic [lanes_p-1:0][vdw_p-1:0]                      wr_data_i,
    output logic                                               wr_ready_o,
    output logic [els_p-1:0]                                   busy_o
);

    localparam int ra_w     = $clog2(els_p);
    localparam int vl_w     = $clog2(vlen_p + 1);
    localparam int beats_lp = vlen_p / lanes_p;
    localparam int bw_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;

    logic [els_p-1:0][vlen_p-1:0][vdw_p-1:0] mem_r;
    logic [els_p-1:0]                        busy_r;
    wr_state_e                               wr_state_r, wr_state_n;
    logic [ra_w-1:0]                         wr_reg_r;
    logic [vl_w-1:0]                         wr_vl_r;
    logic [bw_lp-1:0]                        wr_cnt_r;
    logic [vl_w-1:0]                         wr_vl_c;
    logic [max_lanes_lp-1:0]                 wr_mask;
    logic                                    wr_accept, wr_take, wr_last, war_hit;

    logic [rd_ports_p-1:0]                   rd_stream;
    logic [rd_ports_p-1:0][ra_w-1:0]         rd_reg;
    logic [rd_ports_p-1:0]                   rd_ok;
    logic [rd_ports_p-1:0][bw_lp:0]          rd_avail;

    assign busy_o         = busy_r;
    assign wr_vl_c        = vl_w'(clamp_vl_f(32'(wr_req_vl_i), vlen_p));
    assign wr_req_ready_o = (wr_state_r == eWrIdle) && !war_hit;
    assign wr_accept      = wr_req_v_i && wr_req_ready_o;
    assign wr_ready_o     = (wr_state_r == eWrite);
    assign wr_take        = wr_v_i && wr_ready_o;
    assign wr_last        = ((32'(wr_cnt_r) + 1) == beats_f(32'(wr_vl_r), lanes_p));
    assign wr_mask        = mask_f(32'(wr_cnt_r), 32'(wr_vl_r), lanes_p);

    // A write may not start on a register some port is still streaming out.
    always_comb begin
        war_hit = 1'b0;
        for (int p = 0; p < rd_ports_p; p++) begin
            if (rd_stream[p] && rd_reg[p] == wr_req_reg_i) war_hit = 1'b1;
        end
    end

    always_comb begin
        for (int p = 0; p < rd_ports_p; p++) begin
            rd_ok[p]    = !busy_r[rd_req_reg_i[p]];
            rd_avail[p] = (bw_lp + 1)'(beats_lp);
`ifdef VRF_CHAIN_EN
            if (wr_state_r == eWrite && wr_reg_r == rd_req_reg_i[p]) rd_ok[p] = 1'b1;
            if (wr_state_r == eWrite && wr_reg_r == rd_reg[p]) rd_avail[p] = {1'b0, wr_cnt_r};
`endif
        end
    end

    always_comb begin
        wr_state_n = wr_state_r;
        case (wr_state_r)
            eWrIdle: if (wr_accept && wr_vl_c != '0) wr_state_n = eWrite;
            eWrite:  if (wr_take && wr_last) wr_state_n = eWrIdle;
            default: wr_state_n = eWrIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: storage is cleared on reset because reads after reset must return zeros; it cannot map to a plain RAM.
            mem_r      <= '0;
            busy_r     <= '0;
            wr_state_r <= eWrIdle;
            wr_reg_r   <= '0;
            wr_vl_r    <= '0;
            wr_cnt_r   <= '0;
        end else begin
            wr_state_r <= wr_state_n;
            if (wr_accept) begin
                wr_reg_r <= wr_req_reg_i;
                wr_vl_r  <= wr_vl_c;
                wr_cnt_r <= '0;
                if (wr_vl_c != '0) busy_r[wr_req_reg_i] <= 1'b1;
            end
            if (wr_take) begin
                for (int l = 0; l < lanes_p; l++) begin
                    if (wr_mask[l]) mem_r[wr_reg_r][32'(wr_cnt_r) * lanes_p + l] <= wr_data_i[l];
                end
                wr_cnt_r <= wr_cnt_r + 1'b1;
                if (wr_last) busy_r[wr_reg_r] <= 1'b0;
            end
        end
    end

    for (genvar p = 0; p < rd_ports_p; p++) begin : g_rd
        vrf_rd_seq #(
            .els_p  (els_p),
            .vlen_p (vlen_p),
            .vdw_p  (vdw_p),
            .lanes_p(lanes_p)
        ) u_seq (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .req_v_i    (rd_req_v_i[p]),
            .req_reg_i  (rd_req_reg_i[p]),
            .req_vl_i   (rd_req_vl_i[p]),
            .req_ok_i   (rd_ok[p]),
            .req_ready_o(rd_req_ready_o[p]),
            .mem_i      (mem_r),
            .avail_i    (rd_avail[p]),
            .v_o        (rd_v_o[p]),
            .data_o     (rd_data_o[p]),
            .mask_o     (rd_mask_o[p]),
            .last_o     (rd_last_o[p]),
            .yumi_i     (rd_yumi_i[p]),
            .stream_o   (rd_stream[p]),
            .reg_o      (rd_reg[p])
        );
    end

endmodule

// File: tb/tb_vrf_stream.sv
// Directed bench for vrf_stream: a reference model of register contents feeds
// per-port queues of expected beats that are compared as the DUT streams them.
module tb_vrf_stream;

    localparam int ELS = 32, VLEN = 8, VDW = 32, LANES = 4, RP = 2;

    logic                            clk_i = 1'b0;
    logic                            reset_i;
    logic [RP-1:0]                   rd_req_v_i;
    logic [RP-1:0][4:0]              rd_req_reg_i;
    logic [RP-1:0][3:0]              rd_req_vl_i;
    logic [RP-1:0]                   rd_req_ready_o;
    logic [RP-1:0]                   rd_v_o;
    logic [RP-1:0][LANES-1:0][VDW-1:0] rd_data_o;
    logic [RP-1:0][LANES-1:0]        rd_mask_o;
    logic [RP-1:0]                   rd_last_o;
    logic [RP-1:0]                   rd_yumi_i;
    logic                            wr_req_v_i;
    logic [4:0]                      wr_req_reg_i;
    logic [3:0]                      wr_req_vl_i;
    logic                            wr_req_ready_o;
    logic                            wr_v_i;
    logic [LANES-1:0][VDW-1:0]       wr_data_i;
    logic                            wr_ready_o;
    logic [ELS-1:0]                  busy_o;

    typedef struct {
        logic [LANES-1:0][VDW-1:0] data;
        logic [LANES-1:0]          mask;
        logic                      last;
    } beat_t;

    beat_t       q0[$];
    beat_t       q1[$];
    logic [VDW-1:0] model [ELS][VLEN];
    int          checks   = 0;
    int          failures = 0;

    vrf_stream #(.els_p(ELS), .vlen_p(VLEN), .vdw_p(VDW), .lanes_p(LANES), .rd_ports_p(RP)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .rd_req_v_i(rd_req_v_i), .rd_req_reg_i(rd_req_reg_i), .rd_req_vl_i(rd_req_vl_i),
        .rd_req_ready_o(rd_req_ready_o), .rd_v_o(rd_v_o), .rd_data_o(rd_data_o),
        .rd_mask_o(rd_mask_o), .rd_last_o(rd_last_o), .rd_yumi_i(rd_yumi_i),
        .wr_req_v_i(wr_req_v_i), .wr_req_reg_i(wr_req_reg_i), .wr_req_vl_i(wr_req_vl_i),
        .wr_req_ready_o(wr_req_ready_o), .wr_v_i(wr_v_i), .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < ELS; r++)
            for (int e = 0; e < VLEN; e++) model[r][e] = '0;
        q0.delete();
        q1.delete();
    endtask

    task automatic push_beats(int p, int r, int vl);
        int v, nb;
        beat_t e;
        v  = (vl > VLEN) ? VLEN : vl;
        nb = (v + LANES - 1) / LANES;
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < LANES; l++) begin
                e.data[l] = model[r][b*LANES+l];
                e.mask[l] = ((b*LANES + l) < v);
            end
            e.last = (b == nb - 1);
            if (p == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic rd_req(int p, int r, int vl);
        int n = 0;
        rd_req_reg_i[p] = 5'(r);
        rd_req_vl_i[p]  = 4'(vl);
        rd_req_v_i[p]   = 1'b1;
        #1;
        while (rd_req_ready_o[p] !== 1'b1 && n < 50) begin step(); n++; end
        check($sformatf("rd_req_ready_p%0d_r%0d", p, r), rd_req_ready_o[p], 1);
        push_beats(p, r, vl);
        step();
        rd_req_v_i[p] = 1'b0;
    endtask

    task automatic rd_beat(int p);
        int n = 0;
        beat_t e;
        while (rd_v_o[p] !== 1'b1 && n < 50) begin step(); n++; end
        check($sformatf("rd_v_p%0d", p), rd_v_o[p], 1);
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            check($sformatf("rd_unexpected_beat_p%0d", p), rd_v_o[p], 0);
            return;
        end
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("rd_data_p%0d", p), rd_data_o[p], e.data);
        check($sformatf("rd_mask_p%0d", p), rd_mask_o[p], e.mask);
        check($sformatf("rd_last_p%0d", p), rd_last_o[p], e.last);
        rd_yumi_i[p] = 1'b1;
        step();
        rd_yumi_i[p] = 1'b0;
    endtask

    task automatic drive_wr_beat(int r, int b, int vl, logic [VDW-1:0] base, logic [VDW-1:0] inc);
        for (int l = 0; l < LANES; l++) begin
            wr_data_i[l] = base + inc * (b*LANES + l);
            if ((b*LANES + l) < vl) model[r][b*LANES+l] = wr_data_i[l];
        end
        wr_v_i = 1'b1;
    endtask

    task automatic wr_vec(int r, int vl, logic [VDW-1:0] base, logic [VDW-1:0] inc);
        int n = 0, v, nb;
        wr_req_reg_i = 5'(r);
        wr_req_vl_i  = 4'(vl);
        wr_req_v_i   = 1'b1;
        #1;
        while (wr_req_ready_o !== 1'b1 && n < 50) begin step(); n++; end
        check($sformatf("wr_req_ready_r%0d", r), wr_req_ready_o, 1);
        step();
        wr_req_v_i = 1'b0;
        v  = (vl > VLEN) ? VLEN : vl;
        nb = (v + LANES - 1) / LANES;
        for (int b = 0; b < nb; b++) begin
            drive_wr_beat(r, b, v, base, inc);
            #1;
            check($sformatf("wr_ready_r%0d_b%0d", r, b), wr_ready_o, 1);
            step();
        end
        wr_v_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        rd_req_v_i = '0; rd_req_reg_i = '0; rd_req_vl_i = '0; rd_yumi_i = '0;
        wr_req_v_i = 1'b0; wr_req_reg_i = '0; wr_req_vl_i = '0; wr_v_i = 1'b0; wr_data_i = '0;
        model_reset();
        repeat (3) step();
        check("reset_rd_v", rd_v_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_wr_ready", wr_ready_o, 0);
        reset_i = 1'b0;
        step();
        check("idle_rd_req_ready", rd_req_ready_o, 2'b11);
        check("idle_wr_req_ready", wr_req_ready_o, 1);

        // Full-length write then read back.
        wr_vec(5, 8, 32'd0, 32'd1);
        rd_req(0, 5, 8);
        rd_beat(0); rd_beat(0);

        // Partial write over all-0xFF keeps the tail; partial read masks it.
        wr_vec(3, 8, 32'hFF, 32'd0);
        wr_vec(3, 6, 32'd0, 32'd1);
        rd_req(0, 3, 8);
        rd_beat(0); rd_beat(0);
        rd_req(1, 3, 6);
        rd_beat(1); rd_beat(1);

        // Zero-length read emits nothing; oversize read is clamped.
        rd_req(0, 5, 0);
        check("vl0_no_beat", rd_v_o[0], 0);
        check("vl0_ready_again", rd_req_ready_o[0], 1);
        rd_req(1, 5, 15);
        rd_beat(1); rd_beat(1);

        // Zero-length write sets no busy and streams no beats.
        wr_vec(9, 0, 32'd0, 32'd0);
        check("wvl0_busy", busy_o, 0);
        check("wvl0_wr_ready", wr_ready_o, 0);

        // RAW block on r7 while r8 stays readable.
        wr_req_reg_i = 5'd7; wr_req_vl_i = 4'd8; wr_req_v_i = 1'b1;
        step();
        wr_req_v_i = 1'b0;
        rd_req_reg_i[0] = 5'd7; rd_req_reg_i[1] = 5'd8;
        #1;
        check("raw_busy_r7", busy_o, 32'h80);
        check("raw_block_r7", rd_req_ready_o[0], 0);
        check("raw_free_r8", rd_req_ready_o[1], 1);
        drive_wr_beat(7, 0, 8, 32'h700, 32'd1);
        step();
        check("raw_block_r7_b1", rd_req_ready_o[0], 0);
        drive_wr_beat(7, 1, 8, 32'h700, 32'd1);
        #1;
        check("raw_block_commit_cycle", rd_req_ready_o[0], 0);
        step();
        wr_v_i = 1'b0;
        #1;
        check("raw_release_r7", rd_req_ready_o[0], 1);
        check("raw_busy_clear", busy_o, 0);
        rd_req(0, 7, 8);
        rd_beat(0); rd_beat(0);
        rd_req(1, 8, 8);
        rd_beat(1); rd_beat(1);

        // WAR block on r2 while both ports stream it.
        wr_vec(2, 8, 32'h200, 32'd3);
        rd_req(1, 2, 8);
        wr_req_reg_i = 5'd2;
        #1;
        check("war_block_r2", wr_req_ready_o, 0);
        wr_req_reg_i = 5'd9;
        #1;
        check("war_free_r9", wr_req_ready_o, 1);
        rd_req(0, 2, 8);
        fork
            rd_beat(0);
            rd_beat(1);
        join
        rd_beat(0);
        wr_req_reg_i = 5'd2;
        #1;
        check("war_block_until_last", wr_req_ready_o, 0);
        rd_beat(1);
        check("war_release_r2", wr_req_ready_o, 1);

        // Reset in the middle of a read and a write.
        wr_vec(6, 8, 32'h600, 32'd1);
        rd_req(0, 6, 8);
        wr_req_reg_i = 5'd10; wr_req_vl_i = 4'd8; wr_req_v_i = 1'b1;
        step();
        wr_req_v_i = 1'b0;
        drive_wr_beat(10, 0, 8, 32'hA00, 32'd1);
        step();
        check("mid_rd_v", rd_v_o[0], 1);
        check("mid_busy_r10", busy_o[10], 1);
        wr_v_i = 1'b0;
        reset_i = 1'b1;
        step();
        check("mreset_rd_v", rd_v_o, 0);
        check("mreset_busy", busy_o, 0);
        check("mreset_wr_ready", wr_ready_o, 0);
        reset_i = 1'b0;
        model_reset();
        rd_req(0, 6, 8);
        rd_beat(0); rd_beat(0);
        rd_req(1, 10, 8);
        rd_beat(1); rd_beat(1);

`ifdef VRF_CHAIN_EN
        // Chained read of r4 trails the write beat by beat.
        wr_req_reg_i = 5'd4; wr_req_vl_i = 4'd8; wr_req_v_i = 1'b1;
        #1;
        check("chain_wr_req_ready", wr_req_ready_o, 1);
        step();
        wr_req_v_i = 1'b0;
        rd_req_reg_i[0] = 5'd4; rd_req_vl_i[0] = 4'd8; rd_req_v_i[0] = 1'b1;
        #1;
        check("chain_rd_accept", rd_req_ready_o[0], 1);
        step();
        rd_req_v_i[0] = 1'b0;
        check("chain_wait_b0", rd_v_o[0], 0);
        drive_wr_beat(4, 0, 8, 32'h400, 32'd5);
        step();
        drive_wr_beat(4, 1, 8, 32'h400, 32'd5);
        push_beats(0, 4, 8);
        rd_beat(0);
        wr_v_i = 1'b0;
        rd_beat(0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
